// File: rtl/queue_pkg.sv
// Shared types and default constants for the queue controller and the
// 8-entry byte queue it drives.
//   state_t : controller FSM states
//   op_t    : operation latched at grant time
package queue_pkg;

  localparam int Q_DATA_W = 8;
  localparam int Q_LEN_W  = 4;
  localparam int Q_DEPTH  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic {
    OP_WR = 1'b0,
    OP_RD = 1'b1
  } op_t;

endpackage

// File: rtl/queue_ctrl.sv
// queue_ctrl: arbitrates level-held write/read requests from two requesters,
// issues single-cycle enqueue/dequeue strobes to the byte queue, waits a fixed
// settle period, then acknowledges the requester (and returns read data).
//
// Build option: QCTRL_DROP_ON_FULL_EN
//   defined   : a write granted while full is acked without enqueue and
//               wr_drop_out pulses with the ack.
//   undefined : a write granted while full is withdrawn and stays pending;
//               wr_drop_out does not exist.
//
// Ports:
//   clock_10KHZ  in   system clock
//   reset        in   async active-high reset
//   wr_req_in    in   write request, held until wr_ack_out
//   wr_data_in   in   byte to enqueue
//   wr_ack_out   out  one-cycle write acknowledge
//   rd_req_in    in   read request, held until rd_ack_out
//   rd_ack_out   out  one-cycle read acknowledge
//   rd_valid_out out  with rd_ack_out: 1 = data valid, 0 = queue was empty
//   rd_data_out  out  last dequeued byte
//   len_in       in   queue occupancy
//   q_data_in    in   queue output byte
//   enqueue_out  out  enqueue strobe
//   dequeue_out  out  dequeue strobe
//   q_data_out   out  byte presented to queue input
//   wr_drop_out  out  (option only) write dropped because queue full
//   full_out     out  len_in >= DEPTH (combinational)
//   empty_out    out  len_in == 0 (combinational)
//
// state  | meaning
// IDLE   | sample requests, arbitrate, latch op / write data
// ISSUE  | strobe enqueue or dequeue for one cycle
// SETTLE | wait SETTLE_CYC cycles; last edge captures read data and acks
// DONE   | ack visible for one cycle, then back to IDLE
module queue_ctrl
  import queue_pkg::*;
#(
  parameter int DATA_W     = Q_DATA_W,
  parameter int LEN_W      = Q_LEN_W,
  parameter int DEPTH      = Q_DEPTH,
  parameter int SETTLE_CYC = 2
) (
  input  logic              clock_10KHZ,
  input  logic              reset,
  input  logic              wr_req_in,
  input  logic [DATA_W-1:0] wr_data_in,
  output logic              wr_ack_out,
  input  logic              rd_req_in,
  output logic              rd_ack_out,
  output logic              rd_valid_out,
  output logic [DATA_W-1:0] rd_data_out,
  input  logic [LEN_W-1:0]  len_in,
  input  logic [DATA_W-1:0] q_data_in,
  output logic              enqueue_out,
  output logic              dequeue_out,
  output logic [DATA_W-1:0] q_data_out,
`ifdef QCTRL_DROP_ON_FULL_EN
  output logic              wr_drop_out,
`endif
  output logic              full_out,
  output logic              empty_out
);

  localparam logic [LEN_W-1:0] DEPTH_L   = LEN_W'(DEPTH);
  localparam logic [3:0]       SETTLE_M1 = 4'(SETTLE_CYC - 1);

  state_t            r_state;
  op_t               r_op;
  op_t               r_last_grant;
  logic [3:0]        r_cnt;
  logic              r_enq;
  logic              r_deq;
  logic              r_wr_ack;
  logic              r_rd_ack;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic [DATA_W-1:0] r_q_data;
  logic              r_wr_drop;

  logic w_full;
  logic w_empty;
  logic w_any_req;
  logic w_pick_wr;

  assign w_full    = (len_in >= DEPTH_L);
  assign w_empty   = (len_in == '0);
  assign w_any_req = wr_req_in | rd_req_in;
  // Write wins when it is alone, or when both pend and read had the last turn.
  assign w_pick_wr = wr_req_in & (~rd_req_in | (r_last_grant == OP_RD));

  always_ff @(posedge clock_10KHZ or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_op         <= OP_WR;
      r_last_grant <= OP_RD;
      r_cnt        <= '0;
      r_enq        <= 1'b0;
      r_deq        <= 1'b0;
      r_wr_ack     <= 1'b0;
      r_rd_ack     <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= '0;
      r_q_data     <= '0;
      r_wr_drop    <= 1'b0;
    end else begin
      r_enq      <= 1'b0;
      r_deq      <= 1'b0;
      r_wr_ack   <= 1'b0;
      r_rd_ack   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_wr_drop  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            // last_grant advances even on a withdrawn write so a pending
            // read wins the next round instead of starving behind it.
            r_last_grant <= w_pick_wr ? OP_WR : OP_RD;
            r_op         <= w_pick_wr ? OP_WR : OP_RD;
            if (w_pick_wr) begin
              r_q_data <= wr_data_in;
              if (w_full) begin
`ifdef QCTRL_DROP_ON_FULL_EN
                r_state   <= DONE;
                r_wr_ack  <= 1'b1;
                r_wr_drop <= 1'b1;
`else
                r_state   <= IDLE;
`endif
              end else begin
                r_state <= ISSUE;
                r_enq   <= 1'b1;
              end
            end else if (w_empty) begin
              r_state    <= DONE;
              r_rd_ack   <= 1'b1;
              r_rd_valid <= 1'b0;
            end else begin
              r_state <= ISSUE;
              r_deq   <= 1'b1;
            end
          end
        end
        ISSUE: begin
          r_state <= SETTLE;
          r_cnt   <= SETTLE_M1;
        end
        SETTLE: begin
          if (r_cnt == '0) begin
            r_state <= DONE;
            if (r_op == OP_WR) begin
              r_wr_ack <= 1'b1;
            end else begin
              r_rd_ack   <= 1'b1;
              r_rd_valid <= 1'b1;
              r_rd_data  <= q_data_in;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign enqueue_out  = r_enq;
  assign dequeue_out  = r_deq;
  assign wr_ack_out   = r_wr_ack;
  assign rd_ack_out   = r_rd_ack;
  assign rd_valid_out = r_rd_valid;
  assign rd_data_out  = r_rd_data;
  assign q_data_out   = r_q_data;
  assign full_out     = w_full;
  assign empty_out    = w_empty;
`ifdef QCTRL_DROP_ON_FULL_EN
  assign wr_drop_out  = r_wr_drop;
`else
  logic w_unused;
  assign w_unused = r_wr_drop;
`endif

endmodule

// File: tb/tb_queue_ctrl.sv
module tb_queue_ctrl;
  import queue_pkg::*;

  logic       clock_10KHZ = 1'b0;
  logic       reset;
  logic       wr_req_in;
  logic [7:0] wr_data_in;
  logic       wr_ack_out;
  logic       rd_req_in;
  logic       rd_ack_out;
  logic       rd_valid_out;
  logic [7:0] rd_data_out;
  logic [3:0] len_in;
  logic [7:0] q_data_in;
  logic       enqueue_out;
  logic       dequeue_out;
  logic [7:0] q_data_out;
  logic       full_out;
  logic       empty_out;
`ifdef QCTRL_DROP_ON_FULL_EN
  logic       wr_drop_out;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  queue_ctrl dut (
    .clock_10KHZ (clock_10KHZ),
    .reset       (reset),
    .wr_req_in   (wr_req_in),
    .wr_data_in  (wr_data_in),
    .wr_ack_out  (wr_ack_out),
    .rd_req_in   (rd_req_in),
    .rd_ack_out  (rd_ack_out),
    .rd_valid_out(rd_valid_out),
    .rd_data_out (rd_data_out),
    .len_in      (len_in),
    .q_data_in   (q_data_in),
    .enqueue_out (enqueue_out),
    .dequeue_out (dequeue_out),
    .q_data_out  (q_data_out),
`ifdef QCTRL_DROP_ON_FULL_EN
    .wr_drop_out (wr_drop_out),
`endif
    .full_out    (full_out),
    .empty_out   (empty_out)
  );

  always #5 clock_10KHZ = ~clock_10KHZ;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock_10KHZ);
    #1;
  endtask

  op_t ack_order[4];
  int  n_acks, n_enq, n_deq, n_both, enq_full, wr_ack_full;
  bit  seen, seen_deq;

  initial begin
    reset = 1'b1; wr_req_in = 0; rd_req_in = 0; wr_data_in = 0;
    len_in = 0; q_data_in = 0;
    tick();
    // reset state
    chk("rst_wr_ack", wr_ack_out, 0);
    chk("rst_rd_ack", rd_ack_out, 0);
    chk("rst_strobes", {enqueue_out, dequeue_out}, 0);
    chk("rst_q_data", q_data_out, 0);
    chk("rst_rd_data", rd_data_out, 0);
    chk("rst_flags", {full_out, empty_out}, 2'b01);
    reset = 1'b0;
    tick();

    // 1: single write to empty queue
    wr_data_in = 8'hA5; wr_req_in = 1;         // cycle 0
    tick();                                     // cycle 1
    chk("t1_enq_c1", {enqueue_out, dequeue_out}, 2'b10);
    chk("t1_qdata_c1", q_data_out, 8'hA5);
    tick();                                     // cycle 2
    chk("t1_enq_c2", enqueue_out, 0);
    tick();                                     // cycle 3
    chk("t1_qdata_c3", q_data_out, 8'hA5);
    chk("t1_ack_c3", wr_ack_out, 0);
    tick();                                     // cycle 4
    chk("t1_ack_c4", wr_ack_out, 1);
    tick();
    wr_req_in = 0;
    chk("t1_ack_c5", wr_ack_out, 0);
    tick();

    // 2: read with data available
    len_in = 3; q_data_in = 8'h11; rd_req_in = 1;
    tick();
    chk("t2_deq_c1", {enqueue_out, dequeue_out}, 2'b01);
    tick(); tick(); tick();
    chk("t2_ack_c4", {rd_ack_out, rd_valid_out}, 2'b11);
    chk("t2_rd_data", rd_data_out, 8'h11);
    tick();
    rd_req_in = 0;
    tick();

    // 3: read from empty queue
    len_in = 0; q_data_in = 8'h77; rd_req_in = 1;
    seen = 0; seen_deq = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (dequeue_out) seen_deq = 1;
      if (rd_ack_out) begin seen = 1; break; end
    end
    chk("t3_ack", seen, 1);
    chk("t3_valid", rd_valid_out, 0);
    chk("t3_rd_data_kept", rd_data_out, 8'h11);
    chk("t3_no_deq", seen_deq, 0);
    tick();
    rd_req_in = 0;
    tick();

    // 4: both held from reset -> WR, RD, WR, RD
    reset = 1; len_in = 4; wr_data_in = 8'h3C; q_data_in = 8'h55;
    wr_req_in = 1; rd_req_in = 1;
    tick();
    reset = 0;
    n_acks = 0; n_enq = 0; n_deq = 0; n_both = 0;
    for (int i = 0; i < 40 && n_acks < 4; i++) begin
      tick();
      if (enqueue_out) n_enq++;
      if (dequeue_out) n_deq++;
      if (enqueue_out && dequeue_out) n_both++;
      if (wr_ack_out && n_acks < 4) begin ack_order[n_acks] = OP_WR; n_acks++; end
      if (rd_ack_out && n_acks < 4) begin ack_order[n_acks] = OP_RD; n_acks++; end
    end
    wr_req_in = 0; rd_req_in = 0;
    chk("t4_n_acks", n_acks, 4);
    chk("t4_ack0_wr", ack_order[0], OP_WR);
    chk("t4_ack1_rd", ack_order[1], OP_RD);
    chk("t4_ack2_wr", ack_order[2], OP_WR);
    chk("t4_ack3_rd", ack_order[3], OP_RD);
    chk("t4_n_enq", n_enq, 2);
    chk("t4_n_deq", n_deq, 2);
    chk("t4_no_both", n_both, 0);
    tick(); tick();

`ifndef QCTRL_DROP_ON_FULL_EN
    // 5: full queue stalls the write, read still served
    len_in = 8; q_data_in = 8'h99; wr_data_in = 8'hE1;
    wr_req_in = 1; rd_req_in = 1;
    chk("t5_full_flag", full_out, 1);
    enq_full = 0; wr_ack_full = 0; seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (enqueue_out) enq_full++;
      if (wr_ack_out) wr_ack_full++;
      if (rd_ack_out) begin
        seen = 1;
        chk("t5_rd_valid", rd_valid_out, 1);
        chk("t5_rd_data", rd_data_out, 8'h99);
        rd_req_in = 0;
        break;
      end
    end
    chk("t5_rd_served", seen, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (enqueue_out) enq_full++;
      if (wr_ack_out) wr_ack_full++;
    end
    chk("t5_no_enq_full", enq_full, 0);
    chk("t5_no_ack_full", wr_ack_full, 0);
    len_in = 7;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (enqueue_out) begin
        seen = 1;
        chk("t5_qdata", q_data_out, 8'hE1);
        break;
      end
    end
    chk("t5_enq_after", seen, 1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (wr_ack_out) begin seen = 1; break; end
    end
    chk("t5_wr_ack_after", seen, 1);
    tick();
    wr_req_in = 0;
    tick();
`else
    // 5: full queue drops the write
    len_in = 8; wr_data_in = 8'hE1; wr_req_in = 1; rd_req_in = 0;
    enq_full = 0; seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (enqueue_out) enq_full++;
      if (wr_ack_out) begin
        seen = 1;
        chk("t5_drop", wr_drop_out, 1);
        break;
      end
    end
    chk("t5_ack_drop", seen, 1);
    chk("t5_no_enq", enq_full, 0);
    tick();
    wr_req_in = 0;
    chk("t5_drop_clr", wr_drop_out, 0);
    tick();
`endif

    // 6: reset during SETTLE of a write
    len_in = 0; wr_data_in = 8'h5A; wr_req_in = 1;   // cycle 0
    tick();                                          // cycle 1
    chk("t6_enq_c1", enqueue_out, 1);
    tick();                                          // cycle 2 (SETTLE)
    reset = 1;
    #1;
    chk("t6_async_clear", {enqueue_out, dequeue_out, wr_ack_out, rd_ack_out, q_data_out}, 0);
    tick();
    chk("t6_no_ack_rst", wr_ack_out, 0);
    reset = 0;                                       // cycle 0 again
    tick();                                          // cycle 1
    chk("t6_re_enq", enqueue_out, 1);
    chk("t6_re_qdata", q_data_out, 8'h5A);
    tick(); tick();                                  // cycles 2,3
    chk("t6_ack_c3", wr_ack_out, 0);
    tick();                                          // cycle 4
    chk("t6_ack_c4", wr_ack_out, 1);
    tick();
    wr_req_in = 0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
